vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 101 ++++++++++
 tb/tb_vram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM slot arbiter for a display burst fetcher and two round-robin hosts.
// Optional macro VRAM_ARB_STARVE_GUARD_EN lends every 8th burst slot to a waiting host.
module vram_arbiter #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 disp_start,
    input  logic [ADDR_BITS-1:0] disp_base,
    input  logic [LEN_BITS-1:0]  disp_len,
    output logic                 disp_busy,
    output logic                 disp_rvalid,
    output logic [DATA_BITS-1:0] disp_rdata,
    input  logic                 h0_req,
    input  logic                 h0_we,
    input  logic [ADDR_BITS-1:0] h0_addr,
    input  logic [DATA_BITS-1:0] h0_wdata,
    output logic                 h0_gnt,
    output logic                 h0_rvalid,
    output logic [DATA_BITS-1:0] h0_rdata,
    input  logic                 h1_req,
    input  logic                 h1_we,
    input  logic [ADDR_BITS-1:0] h1_addr,
    input  logic [DATA_BITS-1:0] h1_wdata,
    output logic                 h1_gnt,
    output logic                 h1_rvalid,
    output logic [DATA_BITS-1:0] h1_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic rr, pick1, any_req, host_slot, disp_issue, last, start_ok;
    logic [ADDR_BITS-1:0] base;
    logic [LEN_BITS-1:0] len, cnt;
    // one-hot read tags {disp, h1, h0}: a aligns with mem_addr, b with mem_rdata
    logic [2:0] tag_a, tag_b;

    assign any_req = h0_req | h1_req;
    assign pick1 = rr ? h1_req : !h0_req;
    assign start_ok = (state == IDLE) && disp_start && (disp_len != '0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
    logic guard_used;
    assign host_slot = (state == IDLE) ? any_req : (any_req && cnt[2:0] == 3'd7 && !guard_used);
    always_ff @(posedge clk or posedge reset)
        if (reset) guard_used <= 1'b0;
        else if (disp_issue) guard_used <= 1'b0;
        else if (host_slot && state == BURST) guard_used <= 1'b1;
`else
    assign host_slot = (state == IDLE) && any_req;
`endif
    assign disp_issue = (state == BURST) && !host_slot;
    assign last = disp_issue && (cnt == len - LEN_BITS'(1));
    assign h0_gnt = host_slot && !pick1;
    assign h1_gnt = host_slot && pick1;
    assign disp_busy = (state == BURST);
    assign h0_rvalid = tag_b[0];
    assign h1_rvalid = tag_b[1];
    assign disp_rvalid = tag_b[2];
    assign h0_rdata = h0_rvalid ? mem_rdata : '0;
    assign h1_rdata = h1_rvalid ? mem_rdata : '0;
    assign disp_rdata = disp_rvalid ? mem_rdata : '0;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (start_ok ? BURST : IDLE) : (last ? IDLE : BURST);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            rr <= 1'b0;
            base <= '0;
            len <= '0;
            cnt <= '0;
            mem_addr <= '0;
            mem_we <= 1'b0;
            mem_wdata <= '0;
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                base <= disp_base;
                len <= disp_len;
                cnt <= '0;
            end else if (disp_issue) cnt <= cnt + LEN_BITS'(1);
            if (host_slot) begin
                rr <= !pick1;
                mem_addr <= pick1 ? h1_addr : h0_addr;
                mem_wdata <= pick1 ? h1_wdata : h0_wdata;
            end else if (disp_issue) mem_addr <= base + ADDR_BITS'(cnt);
            mem_we <= host_slot && (pick1 ? h1_we : h0_we);
            tag_a <= {disp_issue, h1_gnt && !h1_we, h0_gnt && !h0_we};
            tag_b <= tag_a;
        end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed table and corner-case sequences for vram_arbiter.
module tb_vram_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic disp_start = 1'b0;
    logic [15:0] disp_base = '0;
    logic [9:0] disp_len = '0;
    logic disp_busy, disp_rvalid;
    logic [31:0] disp_rdata;
    logic h0_req = 1'b0, h0_we = 1'b0, h1_req = 1'b0, h1_we = 1'b0;
    logic [15:0] h0_addr = '0, h1_addr = '0;
    logic [31:0] h0_wdata = '0, h1_wdata = '0;
    logic h0_gnt, h0_rvalid, h1_gnt, h1_rvalid;
    logic [31:0] h0_rdata, h1_rdata;
    logic [15:0] mem_addr;
    logic mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    int checks = 0, failures = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .disp_start(disp_start), .disp_base(disp_base), .disp_len(disp_len),
        .disp_busy(disp_busy), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .h0_req(h0_req), .h0_we(h0_we), .h0_addr(h0_addr), .h0_wdata(h0_wdata),
        .h0_gnt(h0_gnt), .h0_rvalid(h0_rvalid), .h0_rdata(h0_rdata),
        .h1_req(h1_req), .h1_we(h1_we), .h1_addr(h1_addr), .h1_wdata(h1_wdata),
        .h1_gnt(h1_gnt), .h1_rvalid(h1_rvalid), .h1_rdata(h1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [15:0] a);
        return {~a, a};
    endfunction

    // synchronous VRAM model: data for the address presented this cycle appears next cycle
    always @(posedge clk) mem_rdata <= f(mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, disp_rvalid, disp_busy, mem_we,
                 mem_addr, mem_wdata, h0_rdata, h1_rdata, disp_rdata};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        disp_start = 1'b0;
        h0_req = 1'b0;
        h1_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic h0_req, h0_we;
        logic [15:0] h0_addr;
        logic h1_req, h1_we;
        logic [15:0] h1_addr;
        logic g0, g1;
        logic [15:0] m_addr;
        logic m_we;
        logic [31:0] m_wdata;
        logic r0, r1;
        logic [15:0] r_addr;
    } vec_t;

    vec_t vecs[12];
    int gcount, bcount, dcount, rv_seen;
    logic [15:0] ea;

    initial begin
        vecs[0]  = '{1, 0, 16'h0010, 0, 0, 16'h0000, 1, 0, 16'h0010, 0, 32'h0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 0, 16'h0020, 0, 0, 16'h0000, 1, 0, 16'h0020, 0, 32'h0, 0, 0, 16'h0000};
        vecs[2]  = '{1, 0, 16'h0030, 1, 1, 16'h0040, 0, 1, 16'h0040, 1, 32'h0b0b0040, 1, 0, 16'h0010};
        vecs[3]  = '{1, 0, 16'h0030, 1, 1, 16'h0040, 1, 0, 16'h0030, 0, 32'h0, 1, 0, 16'h0020};
        vecs[4]  = '{1, 0, 16'h0031, 1, 0, 16'h0041, 0, 1, 16'h0041, 0, 32'h0, 0, 0, 16'h0000};
        vecs[5]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0041, 0, 32'h0, 1, 0, 16'h0030};
        vecs[6]  = '{0, 0, 16'h0000, 1, 1, 16'h0050, 0, 1, 16'h0050, 1, 32'h0b0b0050, 0, 1, 16'h0041};
        vecs[7]  = '{1, 1, 16'h0060, 1, 0, 16'h0070, 1, 0, 16'h0060, 1, 32'h0a0a0060, 0, 0, 16'h0000};
        vecs[8]  = '{1, 0, 16'h0061, 1, 0, 16'h0070, 0, 1, 16'h0070, 0, 32'h0, 0, 0, 16'h0000};
        vecs[9]  = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0070, 0, 32'h0, 0, 0, 16'h0000};
        vecs[10] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0070, 0, 32'h0, 0, 1, 16'h0070};
        vecs[11] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0070, 0, 32'h0, 0, 0, 16'h0000};

        #1 chk("reset_outputs_async", any_out(), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_outputs", any_out(), 0);

        // host table: grants, registered VRAM port, read returns two cycles after grant
        foreach (vecs[i]) begin
            @(negedge clk);
            h0_req = vecs[i].h0_req; h0_we = vecs[i].h0_we; h0_addr = vecs[i].h0_addr;
            h1_req = vecs[i].h1_req; h1_we = vecs[i].h1_we; h1_addr = vecs[i].h1_addr;
            h0_wdata = {16'h0a0a, h0_addr};
            h1_wdata = {16'h0b0b, h1_addr};
            #1;
            chk($sformatf("vec%0d_h0_gnt", i), h0_gnt, vecs[i].g0);
            chk($sformatf("vec%0d_h1_gnt", i), h1_gnt, vecs[i].g1);
            chk($sformatf("vec%0d_h0_rvalid", i), h0_rvalid, vecs[i].r0);
            chk($sformatf("vec%0d_h1_rvalid", i), h1_rvalid, vecs[i].r1);
            chk($sformatf("vec%0d_h0_rdata", i), h0_rdata, vecs[i].r0 ? f(vecs[i].r_addr) : 32'h0);
            chk($sformatf("vec%0d_h1_rdata", i), h1_rdata, vecs[i].r1 ? f(vecs[i].r_addr) : 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].m_addr);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].m_we);
            if (vecs[i].m_we) chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].m_wdata);
        end

        // both hosts requesting continuously from reset: h0,h1,h0,...
        do_reset();
        h0_req = 1'b1; h0_we = 1'b0; h0_addr = 16'h0100;
        h1_req = 1'b1; h1_we = 1'b0; h1_addr = 16'h0200;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("alt%0d_h0_gnt", i), h0_gnt, (i % 2) == 0);
            chk($sformatf("alt%0d_h1_gnt", i), h1_gnt, (i % 2) == 1);
            @(negedge clk);
        end
        h0_req = 1'b0; h1_req = 1'b0;

        // zero-length start is ignored
        do_reset();
        disp_start = 1'b1; disp_base = 16'h0400; disp_len = 10'd0;
        @(negedge clk);
        disp_start = 1'b0;
        #1 chk("len0_busy", disp_busy, 0);
        @(negedge clk);
        #1 chk("len0_mem_addr", mem_addr, 16'h0000);

        // wrapping 4-word burst with a second start mid-burst
        disp_start = 1'b1; disp_base = 16'hFFFE; disp_len = 10'd4;
        #1 chk("burst_busy_k0", disp_busy, 0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            disp_start = (k == 2);
            if (k == 2) begin disp_base = 16'h1234; disp_len = 10'd7; end
            #1;
            chk($sformatf("burst_busy_k%0d", k), disp_busy, (k >= 1 && k <= 4));
            chk($sformatf("burst_mem_we_k%0d", k), mem_we, 0);
            if (k >= 2) begin
                ea = 16'hFFFE + 16'((k > 5 ? 5 : k) - 2);
                chk($sformatf("burst_mem_addr_k%0d", k), mem_addr, ea);
            end
            chk($sformatf("burst_rvalid_k%0d", k), disp_rvalid, (k >= 3 && k <= 6));
            ea = 16'hFFFE + 16'(k - 3);
            chk($sformatf("burst_rdata_k%0d", k), disp_rdata, (k >= 3 && k <= 6) ? f(ea) : 32'h0);
        end
        disp_start = 1'b0;

        // 16-word burst while h0 keeps requesting
        do_reset();
        disp_start = 1'b1; disp_base = 16'h0300; disp_len = 10'd16;
        @(negedge clk);
        disp_start = 1'b0;
        h0_req = 1'b1; h0_we = 1'b0; h0_addr = 16'h0500;
        gcount = 0; bcount = 0; dcount = 0;
        for (int i = 0; i < 40 && disp_busy; i++) begin
            #1;
            bcount++;
            if (h0_gnt) gcount++;
            if (disp_rvalid) dcount++;
            @(negedge clk);
        end
        #1;
        chk("guard_burst_ended", disp_busy, 0);
        chk("guard_host_after_burst", h0_gnt, 1);
        h0_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (disp_rvalid) dcount++;
            @(negedge clk);
            #1;
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("guard_host_gnts", gcount, 2);
        chk("guard_slots", bcount, 18);
`else
        chk("guard_host_gnts", gcount, 0);
        chk("guard_slots", bcount, 16);
`endif
        chk("guard_disp_rvalids", dcount, 16);

        // reset one cycle after a host read grant
        do_reset();
        h0_req = 1'b1; h0_we = 1'b0; h0_addr = 16'h0777;
        #1 chk("rst_read_gnt", h0_gnt, 1);
        @(negedge clk);
        h0_req = 1'b0;
        reset = 1'b1;
        #1 chk("rst_read_outputs", any_out(), 0);
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (h0_rvalid || h1_rvalid || disp_rvalid) rv_seen++;
            @(negedge clk);
        end
        chk("rst_read_no_rvalid", rv_seen, 0);

        // reset mid-burst abandons it
        disp_start = 1'b1; disp_base = 16'h0900; disp_len = 10'd8;
        @(negedge clk);
        disp_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("midburst_busy", disp_busy, 1);
        reset = 1'b1;
        #1 chk("midburst_reset_outputs", any_out(), 0);
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1 if (disp_rvalid || disp_busy) rv_seen++;
            @(negedge clk);
        end
        chk("midburst_abandoned", rv_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
